// File: rtl/knn_sched.sv
// knn_sched: walks the training-point memory once per start, scores each point
// against a latched test point through the external dist_calc unit, and keeps
// a sorted list of the K nearest distances with their labels.
module knn_sched #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int LABEL_W = 8,
  parameter int K       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_W-1:0]      test_x,
  input  logic [DATA_W-1:0]      test_y,
  input  logic [ADDR_W:0]        n_points,
  output logic                   mem_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_x,
  input  logic [DATA_W-1:0]      mem_y,
  input  logic [LABEL_W-1:0]     mem_label,
  output logic [DATA_W-1:0]      dc_xa,
  output logic [DATA_W-1:0]      dc_ya,
  output logic [DATA_W-1:0]      dc_xb,
  output logic [DATA_W-1:0]      dc_yb,
  input  logic [DATA_W-1:0]      dc_d,
  output logic                   busy,
  output logic                   done,
  output logic [K-1:0]           nn_valid,
  output logic [K*DATA_W-1:0]    nn_dist,
  output logic [K*LABEL_W-1:0]   nn_label
);

  typedef enum logic [2:0] {IDLE, RD, DIST, INS, DONE} state_t;

  state_t               state, state_next;
  logic [ADDR_W:0]      idx;
  logic [ADDR_W:0]      n_r;
  logic [DATA_W-1:0]    d_r;
  logic [LABEL_W-1:0]   l_r;
  logic                 last_point;
  logic [K-1:0]         keep_ahead;
  logic [K-1:0]         ins_valid;
  logic [K*DATA_W-1:0]  ins_dist;
  logic [K*LABEL_W-1:0] ins_label;

  assign dc_xb      = mem_x;
  assign dc_yb      = mem_y;
  assign mem_addr   = idx[ADDR_W-1:0];
  assign last_point = ((idx + 1'b1) == n_r);

  // State register; reset drops any scan in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and the per-state strobes.
  always_comb begin
    state_next = state;
    mem_en     = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE: if (start) state_next = (n_points == '0) ? DONE : RD;
      RD: begin
        mem_en     = 1'b1;
        state_next = DIST;
      end
      DIST: state_next = INS;
      INS:  state_next = last_point ? DONE : RD;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Candidate list after inserting (d_r, l_r). Because the list is sorted and
  // valid slots are packed from slot 0, the slots that stay ahead of the new
  // entry form a prefix; the first slot outside it takes the new entry and
  // everything behind it moves down one place, dropping the last. Using <=
  // keeps an older equal distance ahead of the newcomer. When every slot stays
  // ahead, no slot changes.
  always_comb begin
    ins_valid = nn_valid;
    ins_dist  = nn_dist;
    ins_label = nn_label;
    for (int s = 0; s < K; s++)
      keep_ahead[s] = nn_valid[s] && (nn_dist[s*DATA_W +: DATA_W] <= d_r);
    if (!keep_ahead[0]) begin
      ins_valid[0]                   = 1'b1;
      ins_dist[0 +: DATA_W]          = d_r;
      ins_label[0 +: LABEL_W]        = l_r;
    end
    for (int s = 1; s < K; s++) begin
      if (!keep_ahead[s]) begin
        if (keep_ahead[s-1]) begin
          ins_valid[s]               = 1'b1;
          ins_dist[s*DATA_W +: DATA_W]    = d_r;
          ins_label[s*LABEL_W +: LABEL_W] = l_r;
        end else begin
          ins_valid[s]               = nn_valid[s-1];
          ins_dist[s*DATA_W +: DATA_W]    = nn_dist[(s-1)*DATA_W +: DATA_W];
          ins_label[s*LABEL_W +: LABEL_W] = nn_label[(s-1)*LABEL_W +: LABEL_W];
        end
      end
    end
  end

  // Scan datapath: latch the job on start, capture each distance, update the list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      n_r      <= '0;
      dc_xa    <= '0;
      dc_ya    <= '0;
      d_r      <= '0;
      l_r      <= '0;
      nn_valid <= '0;
      nn_dist  <= '1;
      nn_label <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          idx      <= '0;
          n_r      <= n_points;
          dc_xa    <= test_x;
          dc_ya    <= test_y;
          nn_valid <= '0;
          nn_dist  <= '1;
          nn_label <= '0;
        end
        DIST: begin
          d_r <= dc_d;
          l_r <= mem_label;
        end
        INS: begin
          nn_valid <= ins_valid;
          nn_dist  <= ins_dist;
          nn_label <= ins_label;
          if (!last_point) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/knn_sched.md
# knn_sched

Sequencer for the KNN distance datapath. On `start` it walks a training-point memory of `n_points` entries and feeds each point, paired with a latched test point, through the shared combinational `dist_calc` unit. It keeps a sorted list of the K nearest distances and their labels, and pulses `done` when the scan finishes. It sits between the CPU-facing `knn_core` registers and the point memory / `dist_calc` instance.

## Interface
- `DATA_W`, 32, coordinate and distance width
- `ADDR_W`, 10, point-memory address width
- `LABEL_W`, 8, class label width
- `K`, 4, neighbours kept (≥1)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin scan (sampled in IDLE only)
- `test_x`, `test_y`  in  DATA_W  test point, latched on accepted start
- `n_points`  in  ADDR_W+1  points to scan (0..2^ADDR_W), latched on start
- `mem_en`  out  1  point-memory read enable
- `mem_addr`  out  ADDR_W  read address
- `mem_x`, `mem_y`  in  DATA_W  point data, valid the cycle after `mem_en`
- `mem_label`  in  LABEL_W  label, same timing as `mem_x`
- `dc_xa`, `dc_ya`  out  DATA_W  to `dist_calc` `x_a`/`y_a` (latched test point)
- `dc_xb`, `dc_yb`  out  DATA_W  to `dist_calc` `x_b`/`y_b` (= `mem_x`/`mem_y`, combinational)
- `dc_d`  in  DATA_W  `dist_calc` result, unsigned; smaller is nearer
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse at end of scan
- `nn_valid`  out  K  bit i: slot i holds a neighbour
- `nn_dist`  out  K*DATA_W  slot i at bits [i*DATA_W +: DATA_W]; slot 0 is nearest
- `nn_label`  out  K*LABEL_W  slot i labels, same packing

## Operation
- FSM states: IDLE, RD, DIST, INS, DONE.
- IDLE:
  - When `start`=1: latch test point and `n_points`, clear list (`nn_valid`=0, `nn_dist`=all ones, `nn_label`=0), set index i=0.
  - Go to DONE if `n_points`=0, otherwise to RD.
- RD: `mem_en`=1, `mem_addr`=i; go to DIST.
- DIST: `mem_x`/`mem_y`/`mem_label` valid. Register `dc_d` into d_r and `mem_label` into l_r; go to INS.
- INS:
  - Insertion position p = count of valid slots with `nn_dist` ≤ d_r. Invalid slots count as +infinity.
  - Ties keep the older entry ahead.
  - If p<K: slots p..K-2 shift to p+1..K-1 (slot K-1 is dropped), slot p ← (d_r, l_r, valid=1).
  - If p=K: list is unchanged.
  - If i = `n_points`-1, go to DONE; otherwise i←i+1 and go to RD.
- DONE: `done`=1 for one cycle; go to IDLE.
- `start` outside IDLE is ignored. Test point and `n_points` changes during a scan have no effect.
- Results hold from DONE until the next accepted start.
- `n_points`=2^ADDR_W scans every address. i is ADDR_W+1 bits wide and never wraps.

## Timing
- Reset values:
  - state=IDLE; `busy`, `done`, `mem_en` = 0; `mem_addr`=0.
  - `nn_valid`=0; `nn_dist`=all ones; `nn_label`=0.
  - `dc_xa`/`dc_ya`=0.
- Start accepted at edge E0. From the next cycle:
  - `busy`=1.
  - Point j occupies RD, DIST and INS in cycles 3j+1, 3j+2 and 3j+3.
  - `done`=1 in cycle 3N+1.
  - `busy`=0 from cycle 3N+2.
- With N=0, `done`=1 in cycle 1.
- `start` held high through DONE: a new scan is accepted at the first IDLE edge, giving back-to-back scans with one IDLE cycle between them.
- `rst` asserted mid-scan: immediately return to IDLE and apply reset values; the partial list is discarded.
- Exactly one memory read is issued per point, in address order 0..N-1.

## Test plan
All scenarios use K=4, test point (0,0) and a bench `dist_calc` model that is monotonic in Euclidean distance.

- **Reset state:** assert `rst` → all outputs match the reset values above; `start`=0 keeps `busy`=0.
- **Partial list:** 3 points at x=5,2,9 with labels 1,2,3 → `done` at cycle 10; `nn_valid`=0111; labels in slot order 2,1,3; `mem_addr` sequence 0,1,2.
- **Eviction:** 6 points at x=7,3,8,1,6,2 with labels 10..15 → slot labels 13,15,11,14; `nn_valid`=1111; `done` at cycle 19.
- **Tie ordering:** points x=4,4,4 with labels 1,2,3 → slots hold labels 1,2,3 in that order.
- **Empty scan and ignored start:** `n_points`=0 → `done` at cycle 1 and `nn_valid`=0. Pulse `start` during a 6-point scan → no restart; `done` at cycle 19 only.
- **Reset mid-scan:** assert `rst` in cycle 8 of the 6-point scan → IDLE, `nn_valid`=0. A new start then completes normally with the eviction results above.
